// File: rtl/sar_search_4bit.sv
// Successive-approximation search: drives trial values to an external comparator and recovers the unknown target bit by bit, MSB first.
// The first guess appears one cycle after an accepted start. A search then takes 1 to WIDTH cycles, and done pulses on the following cycle.
module sar_search_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             equal,
  input  logic             greater,
  input  logic             lesser,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result
);

  localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] kept;
  logic             one_hot;

  always_comb begin
    bit_k   = {{(WIDTH-1){1'b0}}, 1'b1} << k;
    kept    = greater ? (guess & ~bit_k) : guess;
    one_hot = ({equal, greater, lesser} == 3'b100) ||
              ({equal, greater, lesser} == 3'b010) ||
              ({equal, greater, lesser} == 3'b001);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      guess  <= '0;
      k      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      error  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= SEARCH;
            guess  <= {1'b1, {(WIDTH-1){1'b0}}};
            k      <= KW'(WIDTH-1);
            busy   <= 1'b1;
            found  <= 1'b0;
            error  <= 1'b0;
            result <= '0;
          end else begin
            guess <= '0;
          end
        end
        SEARCH: begin
          if (!one_hot || equal || (k == '0)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            guess <= '0;
            k     <= '0;
            // A broken comparator invalidates everything decided so far.
            if (!one_hot) begin
              error  <= 1'b1;
              found  <= 1'b0;
              result <= '0;
            end else begin
              found  <= 1'b1;
              result <= equal ? guess : kept;
            end
          end else begin
            guess <= kept | (bit_k >> 1);
            k     <= k - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          guess <= '0;
        end
        default: begin
          state <= IDLE;
          guess <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_4bit.sv
// Bench for sar_search_4bit: per-cycle comparison against a prefix-based search model, plus literal guess sequences.
module tb_sar_search_4bit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] guess;
  logic         equal, greater, lesser;
  logic         busy, done, found, error;
  logic [W-1:0] result;

  int target = 0;
  int fault = 0;  // 0 honest, 1 greater+lesser, 2 no flag, 3 equal+greater
  bit chk_en = 1'b0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // External comparator; fault modes override the honest answer.
  assign equal   = (fault == 0) ? (int'(guess) == target) : (fault == 3);
  assign greater = (fault == 0) ? (int'(guess) >  target) : (fault == 1 || fault == 3);
  assign lesser  = (fault == 0) ? (int'(guess) <  target) : (fault == 1);

  sar_search_4bit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .guess(guess),
    .equal(equal), .greater(greater), .lesser(lesser),
    .busy(busy), .done(done), .found(found), .error(error), .result(result)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Trial at step s keeps the target's top s bits and sets the next bit.
  function automatic int trial(input int t, input int s);
    int hi;
    hi = (t >> (W - s)) << (W - s);
    return hi | (1 << (W - 1 - s));
  endfunction

  int m_phase = 0;  // 0 waiting, 1 searching, 2 reporting
  int m_step = 0;
  int m_guess = 0, m_result = 0;
  bit m_busy = 0, m_done = 0, m_found = 0, m_error = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_step = 0; m_guess = 0; m_result = 0;
      m_busy = 0; m_done = 0; m_found = 0; m_error = 0;
    end else if (m_phase == 0) begin
      m_done = 0;
      if (start) begin
        m_phase = 1; m_step = 0; m_guess = trial(target, 0);
        m_busy = 1; m_found = 0; m_error = 0; m_result = 0;
      end else m_guess = 0;
    end else if (m_phase == 1) begin
      if (fault != 0 || m_guess == target || m_step == W - 1) begin
        if (fault != 0) begin
          m_error = 1; m_found = 0; m_result = 0;
        end else begin
          m_found = 1; m_result = target;
        end
        m_phase = 2; m_busy = 0; m_done = 1; m_guess = 0;
      end else begin
        m_step++;
        m_guess = trial(target, m_step);
      end
    end else begin
      m_done = 0; m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("guess", int'(guess), m_guess);
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("found", int'(found), int'(m_found));
      chk("error", int'(error), int'(m_error));
      chk("result", int'(result), m_result);
    end
  end

  // One honest search with literal expectations; g[] are the expected trial values.
  task automatic run_directed(input int t, input int g0, input int g1, input int g2,
                              input int g3, input int ng);
    int seen[$];
    int exp_g[4];
    bit done_seen;
    exp_g = '{g0, g1, g2, g3};
    done_seen = 0;
    @(negedge clk); target = t; start = 1'b1;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      @(negedge clk); start = 1'b0;
      if (busy) seen.push_back(int'(guess));
      if (done) begin
        done_seen = 1;
        chk($sformatf("t%0d_result", t), int'(result), t);
        chk($sformatf("t%0d_found", t), int'(found), 1);
        chk($sformatf("t%0d_error", t), int'(error), 0);
      end
    end
    chk($sformatf("t%0d_done_seen", t), int'(done_seen), 1);
    chk($sformatf("t%0d_busy_cycles", t), seen.size(), ng);
    for (int i = 0; i < ng && i < seen.size(); i++)
      chk($sformatf("t%0d_guess%0d", t, i), seen[i], exp_g[i]);
  endtask

  initial begin
    bit done_seen;
    int n;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_guess", int'(guess), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_result", int'(result), 0);
    rst = 1'b0;

    run_directed(8, 8, 0, 0, 0, 1);
    run_directed(0, 8, 4, 2, 1, 4);
    run_directed(15, 8, 12, 14, 15, 4);
    run_directed(5, 8, 4, 6, 5, 4);

    // Every target: recovered value and bounded busy time.
    for (int t = 0; t < 16; t++) begin
      @(negedge clk); target = t; start = 1'b1;
      n = 0; done_seen = 0;
      for (int c = 0; c < 20 && !done_seen; c++) begin
        @(negedge clk); start = 1'b0;
        if (busy) n++;
        if (done) begin
          done_seen = 1;
          chk($sformatf("exh%0d_result", t), int'(result), t);
        end
      end
      chk($sformatf("exh%0d_done_seen", t), int'(done_seen), 1);
      chk($sformatf("exh%0d_busy_le4", t), int'(n <= 4), 1);
    end

    // Both magnitude flags on the first guess.
    @(negedge clk); target = 3; fault = 1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("fault_first_guess", int'(guess), 8);
    @(negedge clk);
    chk("fault_done", int'(done), 1);
    chk("fault_error", int'(error), 1);
    chk("fault_found", int'(found), 0);
    chk("fault_result", int'(result), 0);
    fault = 0;
    repeat (2) @(negedge clk);

    // Reset during the second search cycle.
    target = 1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_guess", int'(guess), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_found", int'(found), 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_no_late_done", int'(done), 0);

    // Start held high: one search, a return to idle, then a fresh accept.
    target = 0; start = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    chk("held_done_seen", int'(done_seen), 1);
    @(negedge clk);
    chk("held_idle_busy", int'(busy), 0);
    @(negedge clk);
    chk("held_reaccept_busy", int'(busy), 1);
    chk("held_reaccept_guess", int'(guess), 8);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Random targets, start lengths, late comparator faults and resets.
    for (int it = 0; it < 150; it++) begin
      int hold, fstep, fkind, rstc;
      bit do_fault, do_rst;
      hold = $urandom_range(1, 3);
      do_fault = ($urandom_range(0, 5) == 0);
      fstep = $urandom_range(1, 4);
      fkind = $urandom_range(1, 3);
      do_rst = ($urandom_range(0, 9) == 0);
      rstc = $urandom_range(1, 5);
      target = $urandom_range(0, 15);
      for (int c = 0; c < 10; c++) begin
        start = (c < hold);
        fault = (do_fault && c >= fstep && c < fstep + 2) ? fkind : 0;
        rst = (do_rst && c == rstc);
        @(negedge clk);
      end
      fault = 0; rst = 1'b0; start = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sar_search_4bit.md
SAR_SEARCH_4BIT -- requirements
Module: sar_search_4bit

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 guess  output  WIDTH  trial value, driven to the a input of an external combinational comparator whose b input is the unknown target.
REQ-006 equal  input  1  comparator result, guess == target, same cycle as guess.
REQ-007 greater  input  1  comparator result, guess > target.
REQ-008 lesser  input  1  comparator result, guess < target.
REQ-009 busy  output  1  high while in SEARCH.
REQ-010 done  output  1  one-cycle pulse when a search completes.
REQ-011 found  output  1  result is valid; held until the next accepted start.
REQ-012 error  output  1  flags were not one-hot during the search; held until the next accepted start.
REQ-013 result  output  WIDTH  recovered target value; held until the next accepted start.

Function
REQ-014 FSM states: IDLE, SEARCH, DONE. All outputs are registered.
REQ-015 IDLE with start=1: next state SEARCH; guess <= MSB-only value (1000 for WIDTH=4); bit index k <= WIDTH-1; found, error and result <= 0.
REQ-016 IDLE with start=0: remain in IDLE; guess = 0.
REQ-017 SEARCH: each cycle, sample equal, greater and lesser against the current guess.
REQ-018 Flags not exactly one-hot (none set, or more than one set): next state DONE; error <= 1; found <= 0; result <= 0.
REQ-019 equal=1: next state DONE; result <= guess; found <= 1 (early termination).
REQ-020 greater=1: clear bit k of the kept value.
REQ-021 lesser=1: keep bit k.
REQ-022 When k > 0: next guess = kept value with bit k-1 set; k decrements; remain in SEARCH.
REQ-023 When k == 0 and not equal: result <= kept value; found <= 1; next state DONE.
REQ-024 Latency from start edge to the done pulse is 2 to WIDTH+1 cycles; busy is high for 1 to WIDTH cycles.
REQ-025 DONE lasts exactly one cycle: done=1, busy=0, guess=0; then next state IDLE.
REQ-026 start is ignored in SEARCH and DONE, with no queuing.
REQ-027 result, found and error change only on an accepted start or at search completion.

Reset
REQ-028 rst=1 at a clock edge forces state IDLE; guess, result and k = 0; busy, done, found and error = 0.
REQ-029 Reset has priority over start and over flag evaluation, including mid-SEARCH; no done pulse is generated.
REQ-030 First start is accepted on the first edge with rst=0 and start=1.

Verification
REQ-031 Target 8 (model: equal when guess == 8) -> guesses 8; done after 1 SEARCH cycle; result=8; found=1; error=0.
REQ-032 Target 0 -> guesses 8,4,2,1 all greater; done after 4 SEARCH cycles; result=0; found=1.
REQ-033 Target 15 -> guesses 8,12,14,15; equal on the 4th; result=15; found=1.
REQ-034 Target 5 -> guesses 8,4,6,5; result=5.
REQ-035 Exhaustive targets 0..15 -> result equals target; busy never exceeds 4 cycles.
REQ-036 Fault and control cases:
- greater and lesser both forced to 1 on guess 8 -> next cycle done=1, error=1, found=0, result=0.
- rst asserted during the 2nd SEARCH cycle -> IDLE next cycle, all outputs 0, no done pulse.
- start held high through a search -> exactly one search, then a new search is accepted from IDLE.
